// File: rtl/interrupt_controller_if.sv
// Bus between the interrupt controller and its environment: request lines, mask write port,
// FSM service handshake and the controller's status outputs.
interface interrupt_controller_if #(
    parameter int unsigned NUM_SOURCES  = 15,
    parameter int unsigned VECTOR_WIDTH = 4
);
    logic [NUM_SOURCES-1:0]  irq;
    logic                    mask_we;
    logic [NUM_SOURCES-1:0]  mask_wdata;
    logic                    processing_interrupt;
    logic [VECTOR_WIDTH-1:0] interrupt;
    logic [NUM_SOURCES-1:0]  mask;
    logic [NUM_SOURCES-1:0]  pending;
    logic [NUM_SOURCES-1:0]  in_service;

    modport master (
        output irq, mask_we, mask_wdata, processing_interrupt,
        input  interrupt, mask, pending, in_service
    );

    modport slave (
        input  irq, mask_we, mask_wdata, processing_interrupt,
        output interrupt, mask, pending, in_service
    );
endinterface

// File: rtl/interrupt_controller.sv
// Prioritising interrupt controller: rising-edge capture, enable mask, lowest-index-wins vector
// with a one-request-per-service handshake. Define IRQ_SYNC_EN to add a 2-flop irq synchronizer.
module interrupt_controller #(
    parameter int unsigned NUM_SOURCES  = 15,
    parameter int unsigned VECTOR_WIDTH = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    interrupt_controller_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

    state_e                  state_q;
    logic [VECTOR_WIDTH-1:0] interrupt_q;
    logic [VECTOR_WIDTH-1:0] sel_q;
    logic [NUM_SOURCES-1:0]  in_service_q;
    logic [NUM_SOURCES-1:0]  mask_q;
    logic [NUM_SOURCES-1:0]  pending_q, pending_d;
    logic [NUM_SOURCES-1:0]  irq_s, irq_prev_q, rise;
    logic [NUM_SOURCES-1:0]  eligible, clr_mask;
    logic [VECTOR_WIDTH-1:0] win_idx;
    logic                    clr_req;

`ifdef IRQ_SYNC_EN
    logic [NUM_SOURCES-1:0] irq_meta_q, irq_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_meta_q <= '0;
            irq_sync_q <= '0;
        end else begin
            irq_meta_q <= bus.irq;
            irq_sync_q <= irq_meta_q;
        end
    end

    assign irq_s = irq_sync_q;
`else
    assign irq_s = bus.irq;
`endif

    assign rise     = irq_s & ~irq_prev_q;
    assign eligible = pending_q & mask_q;
    assign clr_req  = (state_q == StReq) && bus.processing_interrupt;
    assign clr_mask = clr_req ? (NUM_SOURCES'(1) << sel_q) : '0;
    // A fresh edge on the bit being cleared wins, so that request is not lost.
    assign pending_d = (pending_q & ~clr_mask) | rise;

    always_comb begin
        win_idx = '0;
        for (int i = int'(NUM_SOURCES) - 1; i >= 0; i--) begin
            if (eligible[i]) win_idx = VECTOR_WIDTH'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
        end else begin
            irq_prev_q <= irq_s;
            pending_q  <= pending_d;
            if (bus.mask_we) mask_q <= bus.mask_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            interrupt_q  <= '0;
            sel_q        <= '0;
            in_service_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|eligible) begin
                        sel_q       <= win_idx;
                        interrupt_q <= win_idx + VECTOR_WIDTH'(1);
                        state_q     <= StReq;
                    end else begin
                        interrupt_q <= '0;
                    end
                end
                // Committed request: held until the FSM acknowledges it.
                StReq: begin
                    if (bus.processing_interrupt) begin
                        in_service_q <= NUM_SOURCES'(1) << sel_q;
                        interrupt_q  <= '0;
                        state_q      <= StService;
                    end
                end
                StService: begin
                    interrupt_q <= '0;
                    if (!bus.processing_interrupt) begin
                        in_service_q <= '0;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    interrupt_q  <= '0;
                    in_service_q <= '0;
                end
            endcase
        end
    end

    assign bus.interrupt  = interrupt_q;
    assign bus.mask       = mask_q;
    assign bus.pending    = pending_q;
    assign bus.in_service = in_service_q;
endmodule
